touch_region_controller: RTL
============================

TOUCH_REGION_CONTROLLER -- requirements
Module: touch_region_controller

Interface
REQ-001 Parameter DEBOUNCE_SAMPLES, default 4: consecutive same-region coordinate samples required to arm a region; legal range 1..15.
REQ-002 Parameter RELEASE_CYCLES, default 16: consecutive Touch_En-low clocks that constitute a pen release; legal range 1..255.
REQ-003 Clock  input  1  system clock, 50 MHz.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Touch_En  input  1  pen-down level from the touch panel controller.
REQ-006 Coord_En  input  1  single-cycle strobe; X_Coord/Y_Coord valid.
REQ-007 X_Coord  input  12  touch X coordinate.
REQ-008 Y_Coord  input  12  touch Y coordinate.
REQ-009 Lock_I  input  1  when high, commits are suppressed.
REQ-010 Mode_I  input  1  0 = increment region colour, 1 = restore region default.
REQ-011 RGB_O  output  8x3  per-region colour code, bit0 = R, bit1 = B, bit2 = G.
REQ-012 Active_Region_O  output  3  candidate or armed region index.
REQ-013 Armed_O  output  1  high while in ARMED.
REQ-014 Commit_O  output  1  one-cycle pulse on each applied commit.

Function
REQ-015 Region index SHALL be {Y_Coord[11], X_Coord[11:10]}, giving 0..7.
REQ-016 The FSM SHALL have the states IDLE, SAMPLE, ARMED and COMMIT.
REQ-017 A sample SHALL be valid only when Coord_En and Touch_En are both high; Coord_En with Touch_En low SHALL be ignored.
REQ-018 IDLE, valid sample:
- candidate <= region, count <= 1
- next state is ARMED if DEBOUNCE_SAMPLES = 1, else SAMPLE.
REQ-019 SAMPLE, valid sample:
- same region: count increments; on reaching DEBOUNCE_SAMPLES, go to ARMED.
- different region: candidate <= new region, count <= 1, stay in SAMPLE.
REQ-020 ARMED, valid sample in a different region: candidate <= new region, count <= 1, go to SAMPLE (or stay in ARMED if DEBOUNCE_SAMPLES = 1).
REQ-021 Release counter:
- clears on any cycle with Touch_En high
- otherwise increments, saturating at RELEASE_CYCLES.
REQ-022 On the release counter reaching RELEASE_CYCLES: SAMPLE goes to IDLE with no commit; ARMED goes to COMMIT.
REQ-023 COMMIT SHALL last exactly one cycle and then go to IDLE.
REQ-024 In COMMIT with Lock_I low:
- Mode_I = 0: RGB_O[candidate] <= RGB_O[candidate] + 1 modulo 8 (3'b111 wraps to 3'b000).
- Mode_I = 1: RGB_O[candidate] <= candidate.
- Commit_O is high that same cycle.
REQ-025 In COMMIT with Lock_I high: no RGB_O change and Commit_O stays low.
REQ-026 RGB_O and Commit_O SHALL be registered; the RGB_O update SHALL be visible on the cycle after COMMIT.
REQ-027 Active_Region_O SHALL show the candidate register; Armed_O SHALL be high exactly in ARMED.
REQ-028 Touch_En rising in the same cycle the release counter would reach its limit SHALL clear the counter, and no release is taken.
REQ-029 Only one region SHALL change per commit; the other seven hold.

Reset
REQ-030 Resetn low SHALL asynchronously force:
- state = IDLE
- candidate = 0, count = 0, release counter = 0
- Armed_O = 0, Commit_O = 0
- RGB_O[i] = i for i = 0..7.
REQ-031 Reset asserted mid-touch SHALL discard any pending commit; after release of reset, the block waits in IDLE for a new valid sample.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the region-index type, and the default colour table constant.
REQ-033 One sub-module, touch_release_timer, SHALL implement the REQ-021 saturating release counter and present a release-reached flag.

Verification
REQ-034 Debounced commit: 4 valid samples at X = 12'h400, Y = 12'h000, then Touch_En low for 16 cycles -> one Commit_O pulse and RGB_O[1] goes 3'b001 to 3'b010.
REQ-035 Short touch: 3 samples in region 5, then release -> no Commit_O and RGB_O unchanged.
REQ-036 Region change: 2 samples in region 0, then 4 in region 6, then release -> only RGB_O[6] changes, 3'b110 to 3'b111; with a second identical sequence, 3'b111 wraps to 3'b000.
REQ-037 Lock and restore:
- Lock_I = 1 during a full commit sequence -> no change and no pulse.
- Lock_I = 0, Mode_I = 1 on modified region 6 -> RGB_O[6] = 3'b110.
REQ-038 Release glitch: in ARMED, Touch_En low for 15 cycles, high for 1, then low for 16 -> exactly one commit, at the end.
REQ-039 Reset mid-operation: assert Resetn in ARMED -> all RGB_O at defaults, no commit, and the next touch sequence behaves as in REQ-034.

Source files
------------

// File: rtl/touch_region_controller_pkg.sv
// Shared types and constants for the touch region controller.
package touch_region_controller_pkg;

  // Region FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StArmed,
    StCommit
  } tr_state_e;

  // Screen region index: {Y msb, X top two bits}.
  typedef logic [2:0] region_t;

  localparam int unsigned NumRegions = 8;

  // Power-on colour of each region equals its own index.
  localparam logic [7:0][2:0] DefaultRgb = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  // Map the coordinate high bits onto a region index.
  function automatic region_t region_of(input logic [1:0] x_hi, input logic y_hi);
    return {y_hi, x_hi};
  endfunction

endpackage

// File: rtl/touch_release_timer.sv
// Saturating pen-up timer: counts consecutive Touch_En-low clocks and flags a release.
module touch_release_timer #(
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic touch_en_i,
  output logic release_o
);

  localparam logic [7:0] Limit = 8'(RELEASE_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Clear while the pen is down, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (touch_en_i) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A pen-down in the same cycle masks the release so a late glitch still cancels it.
  assign release_o = (cnt_q == Limit) && !touch_en_i;

endmodule

// File: rtl/touch_region_controller.sv
// Debounces touch samples into a screen region and, on pen release, commits a
// colour change (increment or restore) to that region's RGB code.
module touch_region_controller
  import touch_region_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned RELEASE_CYCLES   = 16
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Touch_En,
  input  logic            Coord_En,
  input  logic [11:0]     X_Coord,
  input  logic [11:0]     Y_Coord,
  input  logic            Lock_I,
  input  logic            Mode_I,
  output logic [7:0][2:0] RGB_O,
  output logic [2:0]      Active_Region_O,
  output logic            Armed_O,
  output logic            Commit_O
);

  localparam logic [3:0] DebounceCnt = 4'(DEBOUNCE_SAMPLES);

  tr_state_e       state_q, state_d;
  region_t         cand_q, cand_d;
  logic [3:0]      count_q, count_d;
  logic [7:0][2:0] rgb_q, rgb_d;
  logic            commit_q, commit_d;

  logic    sample_valid;
  logic    release_hit;
  logic    commit_fire;
  region_t region;

  // Only the region-selecting coordinate bits matter.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{X_Coord[9:0], Y_Coord[10:0]};

  assign sample_valid = Coord_En && Touch_En;
  assign region       = region_of(X_Coord[11:10], Y_Coord[11]);
  assign commit_fire  = (state_q == StCommit) && !Lock_I;

  touch_release_timer #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_release_timer (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .touch_en_i (Touch_En),
    .release_o  (release_hit)
  );

  // Next-state logic: debounce the candidate region and arm/commit on release.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (sample_valid) begin
          cand_d  = region;
          count_d = 4'd1;
          state_d = (DebounceCnt == 4'd1) ? StArmed : StSample;
        end
      end
      StSample: begin
        if (release_hit) begin
          state_d = StIdle;
        end else if (sample_valid) begin
          if (region == cand_q) begin
            count_d = count_q + 4'd1;
            if (count_d == DebounceCnt) begin
              state_d = StArmed;
            end
          end else begin
            cand_d  = region;
            count_d = 4'd1;
          end
        end
      end
      StArmed: begin
        if (release_hit) begin
          state_d = StCommit;
        end else if (sample_valid && (region != cand_q)) begin
          cand_d  = region;
          count_d = 4'd1;
          if (DebounceCnt != 4'd1) begin
            state_d = StSample;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Colour update and commit pulse, applied only to the candidate region.
  always_comb begin
    rgb_d    = rgb_q;
    commit_d = 1'b0;
    if (commit_fire) begin
      commit_d = 1'b1;
      if (Mode_I) begin
        rgb_d[cand_q] = DefaultRgb[cand_q];
      end else begin
        rgb_d[cand_q] = rgb_q[cand_q] + 3'd1;
      end
    end
  end

  // State and output registers; reset discards any pending commit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      cand_q   <= '0;
      count_q  <= '0;
      rgb_q    <= DefaultRgb;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      rgb_q    <= rgb_d;
      commit_q <= commit_d;
    end
  end

  assign RGB_O           = rgb_q;
  assign Active_Region_O = cand_q;
  assign Armed_O         = (state_q == StArmed);
  assign Commit_O        = commit_q;

endmodule
